// File: rtl/bp_inflight_queue.sv
// bp_inflight_queue: in-order tracker of predicted branches from fetch to execute resolution, drives predictor training and wrong-path flush
module bp_inflight_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_branch,
  input  logic [PC_W-1:0]            fetch_pc,
  input  logic                       fetch_pred,
  input  logic                       resolve_valid,
  input  logic [PC_W-1:0]            resolve_pc,
  input  logic                       resolve_taken,
  input  logic                       squash,
  output logic                       branch_en_EX,
  output logic [PC_W-1:0]            PC_EX,
  output logic                       branch_result,
  output logic                       branch_correction,
  output logic                       fetch_stall,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       proto_err,
  output logic [15:0]                branch_cnt,
  output logic [15:0]                mispredict_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic empty, full, pop, mispred, kill, push, pc_bad;
  always_comb begin
    empty   = occupancy == '0;
    full    = occupancy == OW'(DEPTH);
    pop     = resolve_valid && !empty && !squash;
    mispred = pop && (pred_mem[rd_ptr] != resolve_taken);
    kill    = squash || mispred;
    push    = fetch_branch && !kill && (!full || pop);
    pc_bad  = resolve_valid && !squash && (empty || resolve_pc != pc_mem[rd_ptr]);
    fetch_stall = full;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      pred_mem[wr_ptr] <= fetch_pred;
    end
  end
  // any kill drops every remaining entry by snapping the read pointer to the write pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      occupancy         <= '0;
      branch_en_EX      <= 1'b0;
      PC_EX             <= '0;
      branch_result     <= 1'b0;
      branch_correction <= 1'b0;
      proto_err         <= 1'b0;
      branch_cnt        <= '0;
      mispredict_cnt    <= '0;
    end else begin
      rd_ptr            <= kill ? wr_ptr : rd_ptr + AW'(pop);
      wr_ptr            <= wr_ptr + AW'(push);
      occupancy         <= kill ? '0 : occupancy + OW'(push) - OW'(pop);
      branch_en_EX      <= pop;
      branch_correction <= mispred;
      proto_err         <= proto_err | pc_bad;
      if (pop) begin
        PC_EX         <= pc_mem[rd_ptr];
        branch_result <= resolve_taken;
      end
      if (pop && branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
      if (mispred && mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end
endmodule
